fetch_sequencer: RTL and testbench

Program-counter and fetch stage that sits directly upstream of the 16-bit instruction memory. It drives the memory address bus and captures the returned word into an instruction register. It offers that register to the decode/execute stage over a valid/ready handshake. It resolves jmp locally, resolves jez using an accumulator-zero flag from execute, and stops on hlt or when an address falls outside memory.

---
 rtl/fetch_sequencer.sv | 123 ++++++++++++
 tb/tb_fetch_sequencer.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// PC/fetch stage: drives imem address, captures instruction into ir, offers it
// downstream over valid/ready; resolves jmp locally and jez against execute's acc_zero.
module fetch_sequencer #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16,
  parameter int MEM_DEPTH  = 64,
  parameter int RESET_PC   = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic [ADDR_WIDTH-1:0] imem_abus,
  input  logic [DATA_WIDTH-1:0] imem_dbus,
  output logic [DATA_WIDTH-1:0] ir,
  output logic                  ir_valid,
  input  logic                  ir_ready,
  input  logic                  exec_idle,
  input  logic                  acc_zero,
  output logic                  halted,
  output logic                  fault,
  output logic [15:0]           issue_count
);

  typedef enum logic [1:0] {RUN, BR_WAIT, HALTED, FAULT} state_t;

  localparam logic [3:0]            OP_JMP = 4'h8;
  localparam logic [3:0]            OP_JEZ = 4'hA;
  localparam logic [3:0]            OP_HLT = 4'hE;
  localparam logic [ADDR_WIDTH-1:0] RST_PC = RESET_PC[ADDR_WIDTH-1:0];
  localparam logic [ADDR_WIDTH-1:0] PC_ONE = 1;
  // one extra bit so MEM_DEPTH == 2**ADDR_WIDTH still compares correctly
  localparam logic [ADDR_WIDTH:0]   DEPTH  = MEM_DEPTH[ADDR_WIDTH:0];

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   pc_q, pc_d;
  logic [DATA_WIDTH-1:0]   ir_q, ir_d;
  logic                    irv_q, irv_d;
  logic [11:0]             tgt_q, tgt_d;
  logic                    halted_q, fault_q;
  logic [15:0]             cnt_q;

  logic                    xfer, slot_free, pc_oob;
  logic [3:0]              opcode;
  logic [11:0]             operand;
  logic [ADDR_WIDTH-1:0]   pc_inc;

  assign xfer      = irv_q & ir_ready;
  assign slot_free = ~irv_q | ir_ready;
  assign pc_oob    = {1'b0, pc_q} >= DEPTH;
  assign opcode    = imem_dbus[15:12];
  assign operand   = imem_dbus[11:0];
  assign pc_inc    = pc_q + PC_ONE;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    irv_d   = irv_q & ~xfer;
    tgt_d   = tgt_q;
    unique case (state_q)
      RUN: begin
        if (pc_oob) begin
          state_d = FAULT;
        end else if (slot_free) begin
          unique case (opcode)
            OP_JMP: pc_d = {{(ADDR_WIDTH-12){1'b0}}, operand};
            OP_JEZ: begin
              tgt_d   = operand;
              state_d = BR_WAIT;
            end
            OP_HLT: begin
              ir_d    = imem_dbus;
              irv_d   = 1'b1;
              state_d = HALTED;
            end
            default: begin
              ir_d  = imem_dbus;
              irv_d = 1'b1;
              pc_d  = pc_inc;
            end
          endcase
        end
      end
      // acc_zero only reflects the pre-branch program once ir has drained and execute is idle
      BR_WAIT: begin
        if (!irv_q && exec_idle) begin
          pc_d    = acc_zero ? {{(ADDR_WIDTH-12){1'b0}}, tgt_q} : pc_inc;
          state_d = RUN;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= RUN;
      pc_q     <= RST_PC;
      ir_q     <= '0;
      irv_q    <= 1'b0;
      tgt_q    <= '0;
      halted_q <= 1'b0;
      fault_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      irv_q    <= irv_d;
      tgt_q    <= tgt_d;
      halted_q <= (state_d == HALTED) || (state_d == FAULT);
      fault_q  <= (state_d == FAULT);
      if (xfer) cnt_q <= cnt_q + 16'd1;
    end
  end

  assign imem_abus   = pc_q;
  assign ir          = ir_q;
  assign ir_valid    = irv_q;
  assign halted      = halted_q;
  assign fault       = fault_q;
  assign issue_count = cnt_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: TB-side instruction memory, scoreboard of
// expected issued words popped on every observed handshake.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst_n, ir_ready, exec_idle, acc_zero;
  logic [15:0] imem_abus, imem_dbus, ir, issue_count;
  logic        ir_valid, halted, fault;

  logic [15:0] mem [0:63];
  logic [15:0] exp_q [$];
  int          checks = 0;
  int          errors = 0;

  fetch_sequencer #(.ADDR_WIDTH(16), .DATA_WIDTH(16), .MEM_DEPTH(64), .RESET_PC(0)) dut (
    .clk(clk), .rst_n(rst_n), .imem_abus(imem_abus), .imem_dbus(imem_dbus),
    .ir(ir), .ir_valid(ir_valid), .ir_ready(ir_ready), .exec_idle(exec_idle),
    .acc_zero(acc_zero), .halted(halted), .fault(fault), .issue_count(issue_count)
  );

  always #5 clk = ~clk;

  assign imem_dbus = (imem_abus < 16'd64) ? mem[imem_abus[5:0]] : 16'h0000;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // scoreboard: every transfer must match the next expected word, in order
  always @(negedge clk) begin
    if (rst_n && ir_valid && ir_ready) begin
      if (exp_q.size() == 0) chk("sb_underflow", 32'(exp_q.size()), 32'd1);
      else                   chk("sb_ir", ir, exp_q.pop_front());
    end
  end

  initial begin
    rst_n = 1'b0; ir_ready = 1'b1; exec_idle = 1'b1; acc_zero = 1'b0;
    foreach (mem[i]) mem[i] = 16'h0000;
    mem[0]  = 16'hC00A; mem[1]  = 16'h2000; mem[2]  = 16'hC003;
    mem[3]  = 16'h2001; mem[4]  = 16'h2002; mem[5]  = 16'h8007;
    mem[6]  = 16'hDEAD; mem[7]  = 16'hA00A; mem[10] = 16'hA00D;
    mem[11] = 16'h3011; mem[12] = 16'hE000;
    exp_q = '{16'hC00A, 16'h2000, 16'hC003, 16'h2001, 16'h2002, 16'h3011, 16'hE000};

    #2;
    chk("rst_pc", imem_abus, 0);
    chk("rst_ir", ir, 0);
    chk("rst_irv", ir_valid, 0);
    chk("rst_halted", halted, 0);
    chk("rst_fault", fault, 0);
    chk("rst_cnt", issue_count, 0);
    @(negedge clk) rst_n = 1'b1;

    // straight line
    step; chk("sl_ir0", ir, 16'hC00A); chk("sl_pc1", imem_abus, 1);
    step; chk("sl_ir1", ir, 16'h2000); chk("sl_pc2", imem_abus, 2);
    step; chk("sl_ir2", ir, 16'hC003); chk("sl_pc3", imem_abus, 3);
    step; chk("sl_ir3", ir, 16'h2001); chk("sl_cnt3", issue_count, 3);

    // backpressure
    ir_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step;
      chk("bp_ir", ir, 16'h2001); chk("bp_irv", ir_valid, 1);
      chk("bp_pc", imem_abus, 4);  chk("bp_cnt", issue_count, 3);
    end
    ir_ready = 1'b1;
    step; chk("bp_next", ir, 16'h2002); chk("bp_pc5", imem_abus, 5); chk("bp_cnt4", issue_count, 4);

    // jmp 7, then jez at 7 held by busy execute
    exec_idle = 1'b0;
    step; chk("jmp_pc", imem_abus, 7); chk("jmp_irv", ir_valid, 0); chk("jmp_cnt", issue_count, 5);
    step; chk("jez_pc", imem_abus, 7);
    for (int i = 0; i < 3; i++) begin
      step; chk("jez_wait_pc", imem_abus, 7);
    end
    exec_idle = 1'b1; acc_zero = 1'b1;
    step; chk("jez_taken", imem_abus, 10);
    acc_zero = 1'b0;
    step; chk("jez2_hold", imem_abus, 10);
    step; chk("jez_not_taken", imem_abus, 11);
    step; chk("pre_hlt_ir", ir, 16'h3011); chk("pre_hlt_halted", halted, 0);

    // hlt
    step; chk("hlt_ir", ir, 16'hE000); chk("hlt_irv", ir_valid, 1);
    chk("hlt_halted", halted, 1); chk("hlt_pc", imem_abus, 12);
    step; chk("hlt_drain", ir_valid, 0);
    step(4);
    chk("hlt_pc_frozen", imem_abus, 12); chk("hlt_stay", halted, 1);
    chk("hlt_irv_off", ir_valid, 0); chk("hlt_cnt", issue_count, 7);
    chk("hlt_fault", fault, 0); chk("sb_empty1", 32'(exp_q.size()), 0);

    // fault: jmp out of range
    rst_n = 1'b0;
    mem[0] = 16'h2222; mem[1] = 16'h8040;
    exp_q.push_back(16'h2222);
    #2;
    chk("rst2_halted", halted, 0); chk("rst2_pc", imem_abus, 0);
    @(negedge clk) rst_n = 1'b1;
    step; chk("flt_ir", ir, 16'h2222); chk("flt_pc1", imem_abus, 1);
    step; chk("flt_pc64", imem_abus, 64); chk("flt_early", fault, 0);
    step; chk("flt_fault", fault, 1); chk("flt_halted", halted, 1);
    step(3);
    chk("flt_irv", ir_valid, 0); chk("flt_pc_frozen", imem_abus, 64); chk("flt_stay", fault, 1);
    chk("sb_empty2", 32'(exp_q.size()), 0);

    // async reset while waiting on a jez
    rst_n = 1'b0;
    mem[0] = 16'h2333; mem[1] = 16'hA005;
    exp_q.push_back(16'h2333);
    @(negedge clk) rst_n = 1'b1;
    step; chk("ar_ir", ir, 16'h2333);
    exec_idle = 1'b0;
    step; chk("ar_pc1", imem_abus, 1); chk("ar_cnt1", issue_count, 1);
    step; chk("ar_wait", imem_abus, 1);
    #3 rst_n = 1'b0;
    #1;
    chk("ar_pc0", imem_abus, 0); chk("ar_irv", ir_valid, 0);
    chk("ar_halted", halted, 0); chk("ar_cnt0", issue_count, 0);
    mem[0] = 16'h2444;
    exp_q.push_back(16'h2444);
    exec_idle = 1'b1;
    @(negedge clk) rst_n = 1'b1;
    step; chk("ar_restart_ir", ir, 16'h2444); chk("ar_restart_pc", imem_abus, 1);
    step; chk("sb_empty3", 32'(exp_q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
